// File: rtl/fire_scheduler_if.sv
// Transition-select bus between the fire scheduler and a generated
// synchronous circuit model. The scheduler side is the master: it samples
// control, mask and model nets, and drives the fire index and status.
interface fire_scheduler_if #(
  parameter int N  = 4,
  parameter int FW = $clog2(N + 1)
);
  logic          run;
  logic          step;
  logic          det;
  logic [N-1:0]  mask;
  logic [N-1:0]  precap;
  logic [N-1:0]  value;
  logic [FW-1:0] fire;
  logic          fire_valid;
  logic          step_done;
  logic          deadlock;
  logic [31:0]   fire_count;

  modport master (
    input  run, step, det, mask, precap, value,
    output fire, fire_valid, step_done, deadlock, fire_count
  );

  modport slave (
    output run, step, det, mask, precap, value,
    input  fire, fire_valid, step_done, deadlock, fire_count
  );
endinterface

// File: rtl/fire_scheduler.sv
// Fire scheduler: picks one excited, unmasked transition of a generated
// circuit model and drives its index on `fire` for exactly one cycle.
// Each fire is a SELECT / FIRE / SETTLE sequence, so the model's nets have
// a full cycle to settle before the next decision. Selection is either
// round-robin from the last fired index or offset by a 16-bit LFSR that
// advances once per fire, which keeps random runs reproducible per SEED.
module fire_scheduler #(
  parameter int          N    = 4,
  parameter int          FW   = $clog2(N + 1),
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  fire_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    FIRE,
    SETTLE,
    DEADLOCK
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [FW-1:0] NOOP     = FW'(N);
  localparam logic [FW-1:0] LAST     = FW'(N - 1);
  localparam int            PADW     = (1 << FW);

  state_t        state, state_n;
  logic [FW-1:0] fire_q, fire_n;
  logic          fire_valid_q, fire_valid_n;
  logic          step_done_q, step_done_n;
  logic          deadlock_q, deadlock_n;
  logic [31:0]   fire_count_q, fire_count_n;
  logic [FW-1:0] ptr_q, ptr_n;
  logic [15:0]   lfsr_q, lfsr_n;
  logic          stepping_q, stepping_n;

  logic [N-1:0]    excited;
  logic [PADW-1:0] excited_pad;
  logic            any_excited;
  logic [FW-1:0]   start_rr;
  logic [FW-1:0]   start_rand;
  logic [FW-1:0]   start;
  logic [FW-1:0]   choice;
  logic            found;
  logic [FW:0]     idx;
  logic [15:0]     lfsr_step;

  // Excitation: the DFF would change if enabled, and the transition is allowed.
  assign excited     = (bus.precap ^ bus.value) & bus.mask;
  // Padding lets the scan index the vector with a full FW-bit index.
  assign excited_pad = {{(PADW - N){1'b0}}, excited};
  assign any_excited = |excited;

  assign start_rr   = (ptr_q >= LAST) ? '0 : ptr_q + FW'(1);
  assign start_rand = FW'(lfsr_q % 16'(N));
  assign start      = bus.det ? start_rr : start_rand;
  assign lfsr_step  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Scan N indices modulo N from the start point; the first excited one wins.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    choice = NOOP;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, start} + (FW + 1)'(i);
      if (idx >= (FW + 1)'(N)) begin
        idx = idx - (FW + 1)'(N);
      end
      if (!found && excited_pad[idx[FW-1:0]]) begin
        choice = idx[FW-1:0];
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n      = state;
    fire_n       = fire_q;
    step_done_n  = 1'b0;
    deadlock_n   = deadlock_q;
    fire_count_n = fire_count_q;
    ptr_n        = ptr_q;
    lfsr_n       = lfsr_q;
    stepping_n   = stepping_q;

    unique case (state)
      IDLE: begin
        fire_n = NOOP;
        if (bus.run || bus.step) begin
          state_n    = SELECT;
          stepping_n = !bus.run;
        end
      end

      SELECT: begin
        if (!any_excited) begin
          state_n    = DEADLOCK;
          deadlock_n = 1'b1;
          fire_n     = NOOP;
        end else begin
          state_n = FIRE;
          fire_n  = choice;
        end
      end

      FIRE: begin
        // The model captures at the edge that ends this cycle.
        state_n      = SETTLE;
        fire_n       = NOOP;
        ptr_n        = fire_q;
        fire_count_n = (&fire_count_q) ? fire_count_q : fire_count_q + 32'd1;
        lfsr_n       = lfsr_step;
        // Raised here so the pulse lines up with the SETTLE cycle.
        step_done_n  = stepping_q;
      end

      SETTLE: begin
        fire_n = NOOP;
        if (stepping_q) begin
          state_n = IDLE;
        end else if (bus.run) begin
          state_n = SELECT;
        end else begin
          state_n = IDLE;
        end
      end

      DEADLOCK: begin
        fire_n = NOOP;
        if (any_excited && (bus.run || stepping_q)) begin
          state_n    = SELECT;
          deadlock_n = 1'b0;
        end else if (!bus.run && !stepping_q) begin
          state_n    = IDLE;
          deadlock_n = 1'b0;
        end
      end

      default: begin
        state_n    = IDLE;
        fire_n     = NOOP;
        deadlock_n = 1'b0;
      end
    endcase

    fire_valid_n = (fire_n != NOOP);
  end

  // State and output registers; reset aborts any in-flight fire at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      fire_q       <= NOOP;
      fire_valid_q <= 1'b0;
      step_done_q  <= 1'b0;
      deadlock_q   <= 1'b0;
      fire_count_q <= '0;
      ptr_q        <= LAST;
      lfsr_q       <= SEED_EFF;
      stepping_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      state        <= state_n;
      fire_q       <= fire_n;
      fire_valid_q <= fire_valid_n;
      step_done_q  <= step_done_n;
      deadlock_q   <= deadlock_n;
      fire_count_q <= fire_count_n;
      ptr_q        <= ptr_n;
      lfsr_q       <= lfsr_n;
      stepping_q   <= stepping_n;
    end
  end

  assign bus.fire       = fire_q;
  assign bus.fire_valid = fire_valid_q;
  assign bus.step_done  = step_done_q;
  assign bus.deadlock   = deadlock_q;
  assign bus.fire_count = fire_count_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// Bench for fire_scheduler (N=4). Expected fire indices are pushed to a
// scoreboard queue as each scenario is set up; a negedge monitor pops and
// compares them whenever the DUT shows a valid fire. A tiny DFF model of the
// circuit closes the loop when requested.
module tb_fire_scheduler;

  localparam int N  = 4;
  localparam int FW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fire_scheduler_if #(.N(N), .FW(FW)) bus ();

  fire_scheduler #(.N(N), .FW(FW), .SEED(16'hACE1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic          sb_en  = 1'b0;
  logic          closed = 1'b0;
  logic [2:0]    exp_q[$];
  logic [2:0]    obs_q[$];
  logic [2:0]    run1_q[$];
  int            fire_cyc_q[$];
  int            hist[4];
  int            step_done_cnt = 0;
  int            step_done_cyc = 0;
  logic [2:0]    mon_exp;
  logic [7:0]    exc8;

  assign exc8 = {4'b0000, (bus.precap ^ bus.value) & bus.mask};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop, excitation invariant, step_done bookkeeping.
  always @(negedge clk) begin
    if (sb_en) begin
      check("fire_valid_vs_fire", bus.fire_valid, (bus.fire != 3'd4));
      if (bus.fire_valid) begin
        if (exp_q.size() == 0) begin
          check("fire_unexpected", bus.fire, 4);
        end else begin
          mon_exp = exp_q.pop_front();
          check("fire_seq", bus.fire, mon_exp);
        end
        check("fire_excited", exc8[bus.fire], 1);
        obs_q.push_back(bus.fire);
        fire_cyc_q.push_back(cyc);
        if (bus.fire < 3'd4) hist[bus.fire[1:0]]++;
      end
      if (bus.step_done) begin
        step_done_cnt++;
        step_done_cyc = cyc;
      end
    end
  end

  // One clock: the model DFF enabled by this cycle's fire captures its precap.
  task automatic tick();
    logic [2:0] f;
    f = bus.fire;
    @(posedge clk);
    #1;
    if (closed && f < 3'd4) bus.value[f[1:0]] = bus.precap[f[1:0]];
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    fire_cyc_q.delete();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    step_done_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_deadlock(input string tag, input logic lvl, input int max_cyc);
    int n;
    n = 0;
    while (bus.deadlock !== lvl && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, bus.deadlock, lvl);
  endtask

  task automatic random_run();
    logic [15:0] lf;
    int n;
    lf = 16'hACE1;
    for (int k = 0; k < 1200; k++) begin
      exp_q.push_back(3'(lf % 16'd4));
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
    bus.run = 1'b1;
    n = 0;
    while (bus.fire_count < 32'd1200 && n < 4000) begin
      tick();
      n++;
    end
    bus.run = 1'b0;
    check("rand_count", bus.fire_count, 1200);
    repeat (3) tick();
    check("rand_sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    int c0;
    int diffs;
    bus.run    = 1'b0;
    bus.step   = 1'b0;
    bus.det    = 1'b1;
    bus.mask   = 4'hF;
    bus.precap = 4'h0;
    bus.value  = 4'h0;

    // Reset held with random inputs.
    repeat (4) begin
      bus.run    = 1'($urandom);
      bus.step   = 1'($urandom);
      bus.det    = 1'($urandom);
      bus.mask   = 4'($urandom);
      bus.precap = 4'($urandom);
      bus.value  = 4'($urandom);
      tick();
    end
    check("rst_fire", bus.fire, 4);
    check("rst_fire_valid", bus.fire_valid, 0);
    check("rst_fire_count", bus.fire_count, 0);
    check("rst_deadlock", bus.deadlock, 0);
    check("rst_step_done", bus.step_done, 0);

    // Reset asserted mid-FIRE clears fire within the same cycle.
    bus.run = 1'b0; bus.step = 1'b0; bus.det = 1'b1;
    bus.mask = 4'hF; bus.precap = 4'hF; bus.value = 4'h0;
    reset = 1'b1;
    tick();
    bus.run = 1'b1;
    c0 = 0;
    while (!bus.fire_valid && c0 < 10) begin
      tick();
      c0++;
    end
    check("midfire_seen", bus.fire_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("midfire_rst_fire", bus.fire, 4);
    check("midfire_rst_valid", bus.fire_valid, 0);
    check("midfire_rst_count", bus.fire_count, 0);
    bus.run = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Round-robin, closed loop, excited 1010: fires 1 then 3, then deadlock.
    sb_en = 1'b1;
    do_reset();
    clear_sb();
    closed = 1'b1;
    bus.det = 1'b1; bus.mask = 4'hF; bus.precap = 4'b1010; bus.value = 4'b0000;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    c0 = cyc;
    bus.run = 1'b1;
    wait_deadlock("rr_deadlock", 1'b1, 30);
    check("rr_count", bus.fire_count, 2);
    check("rr_nfires", fire_cyc_q.size(), 2);
    if (fire_cyc_q.size() >= 2) begin
      check("rr_latency", fire_cyc_q[0] - c0, 2);
      check("rr_spacing", fire_cyc_q[1] - fire_cyc_q[0], 3);
    end
    check("rr_deadlock_fire", bus.fire, 4);
    bus.run = 1'b0;
    wait_deadlock("rr_deadlock_clear", 1'b0, 5);
    check("rr_sb_drain", exp_q.size(), 0);

    // Fairness, open loop, excited 1011: 0,1,3 repeating, 9 fires in 27 cycles.
    do_reset();
    clear_sb();
    closed = 1'b0;
    bus.precap = 4'b1011; bus.value = 4'b0000;
    repeat (3) begin
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd3);
    end
    bus.run = 1'b1;
    repeat (27) tick();
    check("fair_count_27", bus.fire_count, 9);
    bus.run = 1'b0;
    repeat (3) tick();
    check("fair_count_stop", bus.fire_count, 9);
    check("fair_sb_drain", exp_q.size(), 0);

    // Single step, excited 0100: one fire of index 2, step_done 3 cycles later.
    do_reset();
    clear_sb();
    closed = 1'b1;
    bus.precap = 4'b0100; bus.value = 4'b0000;
    exp_q.push_back(3'd2);
    c0 = cyc;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    repeat (8) tick();
    check("step_done_cnt", step_done_cnt, 1);
    check("step_done_lat", step_done_cyc - c0, 3);
    check("step_count", bus.fire_count, 1);
    check("step_idle_fire", bus.fire, 4);
    check("step_deadlock", bus.deadlock, 0);
    check("step_sb_drain", exp_q.size(), 0);

    // Mask 1110 over raw excitation 0011: only index 1 fires.
    do_reset();
    clear_sb();
    closed = 1'b0;
    bus.precap = 4'b0011; bus.value = 4'b0000; bus.mask = 4'b1110;
    repeat (5) exp_q.push_back(3'd1);
    bus.run = 1'b1;
    repeat (15) tick();
    bus.run = 1'b0;
    repeat (3) tick();
    check("mask_count", bus.fire_count, 5);
    check("mask_sb_drain", exp_q.size(), 0);

    // Mask 1100: nothing excited, deadlock with fire held at N.
    bus.mask = 4'b1100;
    bus.run  = 1'b1;
    wait_deadlock("mask_deadlock", 1'b1, 10);
    repeat (3) tick();
    check("mask_dl_fire", bus.fire, 4);
    check("mask_dl_count", bus.fire_count, 5);
    bus.run = 1'b0;
    wait_deadlock("mask_dl_clear", 1'b0, 5);

    // Random mode, all excited, 1200 fires; then an identical rerun.
    do_reset();
    clear_sb();
    bus.det = 1'b0; bus.mask = 4'hF; bus.precap = 4'hF; bus.value = 4'h0;
    random_run();
    for (int i = 0; i < 4; i++) check($sformatf("rand_hist%0d_ge200", i), (hist[i] >= 200), 1);
    run1_q = obs_q;
    do_reset();
    clear_sb();
    random_run();
    check("rerun_len", obs_q.size(), run1_q.size());
    diffs = 0;
    for (int i = 0; i < obs_q.size() && i < run1_q.size(); i++) begin
      if (obs_q[i] !== run1_q[i]) diffs++;
    end
    check("rerun_identical_diffs", diffs, 0);

    sb_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
